multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle processor core.
- Sequences instruction fetch, decode, ALU execute, memory access and writeback over multiple clocks, sharing the single ALU between PC increment, address generation and data operations.
- Drives `alu_op` into the ALU decoder, plus datapath mux selects and write enables.
- Gates architectural writes with the condition-check result.

Parameters:
- CNT_W, 32: width of the retired-instruction counter (optional feature).
- TIMEOUT, 255: memory wait cycles before `bus_err` sets; 0 disables the check.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  2  instruction bits [27:26]: 00 data-proc, 01 memory, 10 branch, 11 illegal
- funct  in  6  instruction bits [25:20]; [5]=I (immediate), [0]=S/L (set flags / load)
- rd  in  4  destination register field
- cond_ex  in  1  condition check passed (combinational from condition logic)
- mem_ready  in  1  memory has completed the current access this cycle
- alu_op  out  1  1 selects funct-decoded ALU op; 0 forces ADD
- alu_src_a  out  1  0 = register A, 1 = PC
- alu_src_b  out  2  0 = register B, 1 = extended immediate, 2 = constant 4
- result_src  out  2  0 = ALU out register, 1 = data register, 2 = ALU result direct
- adr_src  out  1  0 = PC, 1 = result bus
- ir_write  out  1  latch instruction register
- mem_w  out  1  memory write strobe
- reg_w  out  1  register file write, gated by `cond_ex`
- pc_write  out  1  PC load enable
- illegal  out  1  one-cycle pulse on `op`=11 decode
- bus_err  out  1  sticky memory timeout flag
- retired  out  CNT_W  retired-instruction count

Behaviour:
- States, 4-bit encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Unused codes go to FETCH on the next clock.
- Reset (async, `rst_n`=0):
  - State goes to FETCH.
  - Wait counter = 0, `bus_err` = 0, `retired` = 0.
  - All outputs are Moore decodes of FETCH with `mem_ready`=0, i.e. all strobes 0.
- Outputs not listed for a state are 0.
- FETCH:
  - Drives `adr_src`=0, `alu_src_a`=1, `alu_src_b`=2, `result_src`=2.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- DECODE:
  - Drives `alu_src_a`=1, `alu_src_b`=2, `result_src`=2 (PC+8 for the register read).
  - Next state by `op`/`funct`:
    - 01 → MEMADR
    - 00 with `funct[5]`=0 → EXECR
    - 00 with `funct[5]`=1 → EXECI
    - 10 → BRANCH
    - 11 → FETCH with `illegal`=1 for this cycle only.
- MEMADR:
  - Drives `alu_src_b`=1, `alu_op`=0.
  - Goes to MEMRD if `funct[0]`=1, otherwise MEMWR.
- MEMRD: drives `adr_src`=1; waits for `mem_ready`, then goes to MEMWB.
- MEMWB: drives `result_src`=1 and `reg_w`=`cond_ex`, then goes to FETCH.
- MEMWR:
  - Drives `adr_src`=1 and `mem_w`=`cond_ex`, held for every wait cycle.
  - Goes to FETCH on `mem_ready`.
  - If `cond_ex`=0, goes to FETCH immediately without waiting.
- EXECR: drives `alu_op`=1, `alu_src_b`=0, then goes to ALUWB.
- EXECI: drives `alu_op`=1, `alu_src_b`=1, then goes to ALUWB.
- ALUWB: drives `result_src`=0 and `reg_w`=`cond_ex`, then goes to FETCH.
- BRANCH:
  - Drives `alu_src_b`=1, `result_src`=2, `pc_write`=`cond_ex`.
  - Goes to FETCH.
- PC as destination: in MEMWB or ALUWB, if `rd`=15 and `cond_ex`=1, then `pc_write`=1 and `reg_w`=0.
- Latency, including the FETCH cycle with `mem_ready` high and no memory wait:
  - data-proc: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
- Wait counter:
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with `mem_ready`=0.
  - Clears on `mem_ready`=1 or on any state change.
  - Saturates at TIMEOUT.
  - On reaching TIMEOUT (when TIMEOUT≠0), `bus_err` sets to 1 and stays set until reset.
  - The FSM keeps waiting after the timeout; there is no abort.
- Reset asserted mid-instruction returns to FETCH with no pending strobe; an in-flight `mem_w` is dropped in the same cycle.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined:
  - `retired` increments by 1, wrapping at 2^CNT_W, on each transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH.
  - Condition-failed instructions are counted.
  - Illegal decodes are not counted.
- Undefined: `retired` is tied to 0 and no counter flops are inferred.

Test Plan:
- ADD register, `mem_ready`=1, `cond_ex`=1, `rd`=3 → state sequence 0,1,6,8,0; `alu_op`=1 only in state 6; `reg_w`=1 only in state 8; `pc_write`=1 only in the FETCH cycle.
- LDR (`op`=01, `funct[0]`=1), `mem_ready` low for 3 cycles in MEMRD → sequence 0,1,2,3,3,3,3,4,0; `adr_src`=1 throughout MEMRD; one `reg_w` pulse in MEMWB.
- STR with `cond_ex`=0 → `mem_w` never asserts; MEMWR goes directly to FETCH; `reg_w`=0 throughout.
- B (`op`=10): with `cond_ex`=1 → `pc_write`=1 in BRANCH; repeated with `cond_ex`=0 → `pc_write`=0 in BRANCH; both return to FETCH after 3 cycles.
- `op`=11 → `illegal` pulses for exactly 1 cycle in DECODE, then FETCH. With TIMEOUT=4 and `mem_ready` held 0 in FETCH → `bus_err`=1 after 4 cycles and stays 1 until `rst_n`=0.
- `rst_n` asserted during MEMWR with `mem_w`=1 → `mem_w`=0 immediately; state=FETCH. With MULTICYCLE_CTRL_PERF_EN defined, after 5 completed ADDs `retired`=5.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl -- main control FSM of the multicycle core.
//
// Sequences fetch / decode / execute / memory / writeback over several
// clocks. The single ALU is shared between the PC increment, address
// generation and data operations. This block drives the ALU decoder, the
// datapath mux selects and the write enables. Architectural writes are
// gated by the condition-check result.
//
// Parameters
//   CNT_W    width of the retired-instruction counter
//   TIMEOUT  memory wait cycles before bus_err sets (0 = check disabled)
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   op, funct, rd       instruction fields [27:26], [25:20], dest register
//   cond_ex             condition check passed (combinational)
//   mem_ready           memory finished the current access this cycle
//   alu_op              1 = funct-decoded ALU op, 0 = force ADD
//   alu_src_a/b         ALU operand selects
//   result_src          0 = ALU out reg, 1 = data reg, 2 = ALU result
//   adr_src             0 = PC, 1 = result bus
//   ir_write, mem_w,
//   reg_w, pc_write     strobes
//   illegal             one-cycle pulse on an op=11 decode
//   bus_err             sticky memory-timeout flag
//   retired             retired-instruction count
//
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN
//   defined   -> retired counts completed instructions
//   undefined -> retired is tied to 0
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       op,
   input  logic [5:0]       funct,
   input  logic [3:0]       rd,
   input  logic             cond_ex,
   input  logic             mem_ready,
   output logic             alu_op,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       result_src,
   output logic             adr_src,
   output logic             ir_write,
   output logic             mem_w,
   output logic             reg_w,
   output logic             pc_write,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_e;

   localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WCNT_W-1:0] TMO    = WCNT_W'(TIMEOUT);
   localparam logic [WCNT_W-1:0] WONE   = WCNT_W'(1);
   localparam logic              TMO_EN = (TIMEOUT != 0);

   state_e            state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              bus_err_q, bus_err_d;
   logic              waiting;

   // funct[4:1] only matter to the ALU decoder, not to sequencing
   logic unused_funct;
   assign unused_funct = ^funct[4:1];

   // ---------------- next-state ----------------
   always_comb begin
      state_d = FETCH;
      unique case (state_q)
         FETCH:  state_d = mem_ready ? DECODE : FETCH;
         DECODE: begin
            unique case (op)
               2'b00:   state_d = funct[5] ? EXECI : EXECR;
               2'b01:   state_d = MEMADR;
               2'b10:   state_d = BRANCH;
               default: state_d = FETCH;   // illegal
            endcase
         end
         MEMADR: state_d = funct[0] ? MEMRD : MEMWR;
         MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
         MEMWB:  state_d = FETCH;
         // a failed-condition store skips the memory handshake entirely
         MEMWR:  state_d = (mem_ready || !cond_ex) ? FETCH : MEMWR;
         EXECR:  state_d = ALUWB;
         EXECI:  state_d = ALUWB;
         ALUWB:  state_d = FETCH;
         BRANCH: state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   // ---------------- output decode ----------------
   always_comb begin
      alu_op     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      result_src = 2'd0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      mem_w      = 1'b0;
      reg_w      = 1'b0;
      pc_write   = 1'b0;
      illegal    = 1'b0;
      unique case (state_q)
         FETCH: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'd2;
            result_src = 2'd2;
            // strobes stay low while reset is held, whatever mem_ready does
            ir_write   = mem_ready & rst_n;
            pc_write   = mem_ready & rst_n;
         end
         DECODE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'd2;
            result_src = 2'd2;
            illegal    = (op == 2'b11);
         end
         MEMADR: begin
            alu_src_b  = 2'd1;
         end
         MEMRD: begin
            adr_src    = 1'b1;
         end
         MEMWB: begin
            result_src = 2'd1;
            // rd=15 redirects the write into the PC
            pc_write   = cond_ex & (rd == 4'd15);
            reg_w      = cond_ex & (rd != 4'd15);
         end
         MEMWR: begin
            adr_src    = 1'b1;
            mem_w      = cond_ex;
         end
         EXECR: begin
            alu_op     = 1'b1;
         end
         EXECI: begin
            alu_op     = 1'b1;
            alu_src_b  = 2'd1;
         end
         ALUWB: begin
            result_src = 2'd0;
            pc_write   = cond_ex & (rd == 4'd15);
            reg_w      = cond_ex & (rd != 4'd15);
         end
         BRANCH: begin
            alu_src_b  = 2'd1;
            result_src = 2'd2;
            pc_write   = cond_ex;
         end
         default: ;
      endcase
   end

   // ---------------- memory wait watchdog ----------------
   // Counts only while parked in a memory-wait state; leaving the state or
   // seeing mem_ready clears it. With TIMEOUT=0 it saturates at 0.
   assign waiting = ((state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR))
                    && !mem_ready && (state_d == state_q);

   always_comb begin
      wcnt_d = '0;
      if (waiting)
         wcnt_d = (wcnt_q == TMO) ? wcnt_q : wcnt_q + WONE;
   end

   assign bus_err_d = bus_err_q | (TMO_EN & waiting & (wcnt_d == TMO));
   assign bus_err   = bus_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         wcnt_q    <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         bus_err_q <= bus_err_d;
      end
   end

   // ---------------- retired-instruction counter ----------------
`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire;

   // completion = leaving a final state for FETCH; illegal decodes go
   // DECODE->FETCH and are therefore not counted
   assign retire = (state_d == FETCH) &&
                   ((state_q == MEMWB) || (state_q == MEMWR) ||
                    (state_q == ALUWB) || (state_q == BRANCH));
   assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) retired_q <= '0;
      else        retired_q <= retired_d;
   end

   assign retired = retired_q;
`else
   assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl -- directed + randomized bench for multicycle_ctrl.
// An instruction-level model walks each instruction through its phases and
// predicts the outputs of every cycle, the sticky bus_err and retired.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  op = '0;
   logic [5:0]  funct = '0;
   logic [3:0]  rd = '0;
   logic        cond_ex = 1'b0;
   logic        mem_ready = 1'b0;
   logic        alu_op, alu_src_a, adr_src, ir_write, mem_w, reg_w, pc_write, illegal, bus_err;
   logic [1:0]  alu_src_b, result_src;
   logic [31:0] retired;

   always #5 clk = ~clk;

   multicycle_ctrl #(.CNT_W(32), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .rd(rd),
      .cond_ex(cond_ex), .mem_ready(mem_ready), .alu_op(alu_op),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
      .adr_src(adr_src), .ir_write(ir_write), .mem_w(mem_w), .reg_w(reg_w),
      .pc_write(pc_write), .illegal(illegal), .bus_err(bus_err), .retired(retired)
   );

   wire [12:0] obs = {alu_op, alu_src_a, alu_src_b, result_src, adr_src,
                      ir_write, mem_w, reg_w, pc_write, illegal};

   typedef enum {PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMRD, PH_MEMWB,
                 PH_MEMWR, PH_EXECR, PH_EXECI, PH_ALUWB, PH_BRANCH} ph_e;

   int          tests = 0;
   int          fails = 0;
   logic        bus_err_m = 1'b0;
   logic [31:0] retired_m = '0;
   logic [1:0]  i_op = '0;
   logic [5:0]  i_funct = '0;
   logic [3:0]  i_rd = '0;
   logic        i_cond = 1'b0;

   // expected output vector of one cycle of a phase
   function automatic logic [12:0] exp_out(ph_e ph, logic mr, logic c,
                                           logic [1:0] o, logic [3:0] r);
      logic aop = 0, asa = 0, ads = 0, irw = 0, mw = 0, rw = 0, pcw = 0, ill = 0;
      logic [1:0] asb = 0, rs = 0;
      case (ph)
         PH_FETCH:  begin asa = 1; asb = 2; rs = 2; irw = mr; pcw = mr; end
         PH_DECODE: begin asa = 1; asb = 2; rs = 2; ill = (o == 2'b11); end
         PH_MEMADR: asb = 1;
         PH_MEMRD:  ads = 1;
         PH_MEMWB:  begin rs = 1; if (r == 15) pcw = c; else rw = c; end
         PH_MEMWR:  begin ads = 1; mw = c; end
         PH_EXECR:  aop = 1;
         PH_EXECI:  begin aop = 1; asb = 1; end
         PH_ALUWB:  begin rs = 0; if (r == 15) pcw = c; else rw = c; end
         PH_BRANCH: begin asb = 1; rs = 2; pcw = c; end
         default: ;
      endcase
      return {aop, asa, asb, rs, ads, irw, mw, rw, pcw, ill};
   endfunction

   task automatic check_all(input string tag, input logic [12:0] e);
      tests++;
      assert (obs === e) else begin
         fails++; $error("FAIL %s outputs got %b want %b", tag, obs, e);
      end
      tests++;
      assert (bus_err === bus_err_m) else begin
         fails++; $error("FAIL %s bus_err got %b want %b", tag, bus_err, bus_err_m);
      end
      tests++;
      assert (retired === retired_m) else begin
         fails++; $error("FAIL %s retired got %0d want %0d", tag, retired, retired_m);
      end
   endtask

   // one clock of a phase: drive at negedge (also releases reset), check 1 later
   task automatic step(input ph_e ph, input logic mr, input string tag);
      @(negedge clk);
      rst_n = 1'b1;
      op = i_op; funct = i_funct; rd = i_rd; cond_ex = i_cond; mem_ready = mr;
      #1;
      check_all(tag, exp_out(ph, mr, i_cond, i_op, i_rd));
   endtask

   // memory wait: nwait cycles of mem_ready=0, then one with mem_ready=1
   task automatic wait_phase(input ph_e ph, input int nwait, input string tag);
      int w = 0;
      for (int i = 0; i < nwait; i++) begin
         step(ph, 1'b0, tag);
         w++;
         if (w >= TMO) bus_err_m = 1'b1;
      end
      step(ph, 1'b1, tag);
   endtask

   task automatic retire_m();
`ifdef MULTICYCLE_CTRL_PERF_EN
      retired_m = retired_m + 1;
`endif
   endtask

   task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                            input logic c, input int fw, input int mw, input string tag);
      i_op = o; i_funct = f; i_rd = r; i_cond = c;
      wait_phase(PH_FETCH, fw, tag);
      step(PH_DECODE, 1'($urandom_range(0, 1)), tag);
      case (o)
         2'b00: begin
            step(f[5] ? PH_EXECI : PH_EXECR, 1'($urandom_range(0, 1)), tag);
            step(PH_ALUWB, 1'($urandom_range(0, 1)), tag);
            retire_m();
         end
         2'b01: begin
            step(PH_MEMADR, 1'($urandom_range(0, 1)), tag);
            if (f[0]) begin
               wait_phase(PH_MEMRD, mw, tag);
               step(PH_MEMWB, 1'($urandom_range(0, 1)), tag);
            end else if (c) begin
               wait_phase(PH_MEMWR, mw, tag);
            end else begin
               step(PH_MEMWR, 1'($urandom_range(0, 1)), tag);
            end
            retire_m();
         end
         2'b10: begin
            step(PH_BRANCH, 1'($urandom_range(0, 1)), tag);
            retire_m();
         end
         default: ;   // illegal: straight back to FETCH
      endcase
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      mem_ready = 1'b0;
      #1;
      bus_err_m = 1'b0;
      retired_m = '0;
      check_all(tag, exp_out(PH_FETCH, 1'b0, 1'b0, 2'b00, 4'd0));
   endtask

   initial begin
      logic [31:0] exp5;
      // reset state
      #2;
      do_reset("reset");

      // five ADDs from reset
      for (int k = 0; k < 5; k++) run_instr(2'b00, 6'h08, 4'd3, 1'b1, 0, 0, "add5");
`ifdef MULTICYCLE_CTRL_PERF_EN
      exp5 = 32'd5;
`else
      exp5 = 32'd0;
`endif
      tests++;
      assert (retired === exp5) else begin
         fails++; $error("FAIL retired_after_5_adds got %0d want %0d", retired, exp5);
      end

      // directed test-plan items
      run_instr(2'b00, 6'h08, 4'd3,  1'b1, 0, 0, "add_reg");
      run_instr(2'b00, 6'h29, 4'd7,  1'b1, 1, 0, "add_imm");
      run_instr(2'b01, 6'h19, 4'd2,  1'b1, 0, 3, "ldr_wait3");
      run_instr(2'b01, 6'h18, 4'd2,  1'b0, 0, 2, "str_cond0");
      run_instr(2'b01, 6'h18, 4'd2,  1'b1, 2, 2, "str_cond1");
      run_instr(2'b10, 6'h00, 4'd0,  1'b1, 0, 0, "b_taken");
      run_instr(2'b10, 6'h00, 4'd0,  1'b0, 0, 0, "b_not_taken");
      run_instr(2'b11, 6'h00, 4'd0,  1'b1, 0, 0, "illegal");
      run_instr(2'b00, 6'h08, 4'd15, 1'b1, 0, 0, "alu_pc_dest");
      run_instr(2'b01, 6'h01, 4'd15, 1'b1, 0, 1, "ldr_pc_dest");
      run_instr(2'b00, 6'h08, 4'd15, 1'b0, 0, 0, "alu_pc_cond0");

      // memory timeout in FETCH: bus_err after TMO waits, sticky afterwards
      run_instr(2'b00, 6'h08, 4'd1, 1'b1, TMO + 2, 0, "timeout_fetch");
      tests++;
      assert (bus_err === 1'b1) else begin
         fails++; $error("FAIL bus_err_sticky got %b want 1", bus_err);
      end
      run_instr(2'b10, 6'h00, 4'd0, 1'b1, 0, 0, "after_timeout");

      // reset in the middle of a store with mem_w asserted
      i_op = 2'b01; i_funct = 6'h00; i_rd = 4'd4; i_cond = 1'b1;
      wait_phase(PH_FETCH, 0, "rst_memwr");
      step(PH_DECODE, 1'b0, "rst_memwr");
      step(PH_MEMADR, 1'b0, "rst_memwr");
      step(PH_MEMWR, 1'b0, "rst_memwr");
      do_reset("rst_memwr_reset");

      // randomized instruction stream
      for (int k = 0; k < 200; k++) begin
         logic [1:0] ro;
         ro = 2'($urandom_range(0, 3));
         run_instr(ro, 6'($urandom), 4'($urandom), 1'($urandom),
                   $urandom_range(0, 5), $urandom_range(0, 5), "random");
      end

      // a final timeout in MEMRD after a clean reset
      @(negedge clk);
      do_reset("reset2");
      run_instr(2'b01, 6'h01, 4'd5, 1'b1, 0, TMO, "timeout_memrd");
      run_instr(2'b00, 6'h08, 4'd5, 1'b1, 0, 0, "post_timeout");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
